// File: rtl/spi_peripheral.sv
// SPI mode-0 peripheral that writes five 8-bit PWM configuration registers.
// Define SPI_READBACK_EN to build register readback on cipo.
module spi_peripheral #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [6:0] MAX_ADDR    = 7'h04
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic       cipo,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SHIFT  = 2'd1;
   localparam logic [1:0] COMMIT = 2'd2;

   // Top bit of sclk/ncs chains is the extra flop used only for edge detection.
   logic [SYNC_STAGES:0]   sclk_q, ncs_q;
   logic [SYNC_STAGES-1:0] copi_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_q <= '0;
         ncs_q  <= '1;
         copi_q <= '0;
      end else begin
         sclk_q <= {sclk_q[SYNC_STAGES-1:0], sclk};
         ncs_q  <= {ncs_q[SYNC_STAGES-1:0], ncs};
         copi_q <= {copi_q[SYNC_STAGES-2:0], copi};
      end
   end

   logic ncs_s, copi_s, sclk_rise, ncs_rise, ncs_fall;
   assign ncs_s     = ncs_q[SYNC_STAGES-1];
   assign copi_s    = copi_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
   assign ncs_rise  = ncs_q[SYNC_STAGES-1]  & ~ncs_q[SYNC_STAGES];
   assign ncs_fall  = ~ncs_q[SYNC_STAGES-1] &  ncs_q[SYNC_STAGES];

   logic [1:0]  state;
   logic [4:0]  cnt;
   logic [15:0] sr;
   logic        frame_ok;

   assign frame_ok = (cnt == 5'd16) && sr[15] && (sr[14:8] <= MAX_ADDR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         cnt             <= '0;
         sr              <= '0;
         en_reg_out_7_0  <= '0;
         en_reg_out_15_8 <= '0;
         en_reg_pwm_7_0  <= '0;
         en_reg_pwm_15_8 <= '0;
         pwm_duty_cycle  <= '0;
      end else begin
         case (state)
            IDLE: if (ncs_fall) begin
               state <= SHIFT;
               cnt   <= '0;
               sr    <= '0;
            end
            SHIFT: begin
               // ncs rise is checked first so a coincident sclk edge is dropped
               if (ncs_rise) state <= frame_ok ? COMMIT : IDLE;
               else if (sclk_rise && !ncs_s) begin
                  sr <= {sr[14:0], copi_s};
                  if (cnt != 5'd17) cnt <= cnt + 5'd1;
               end
            end
            COMMIT: begin
               case (sr[14:8])
                  7'h00:   en_reg_out_7_0  <= sr[7:0];
                  7'h01:   en_reg_out_15_8 <= sr[7:0];
                  7'h02:   en_reg_pwm_7_0  <= sr[7:0];
                  7'h03:   en_reg_pwm_15_8 <= sr[7:0];
                  7'h04:   pwm_duty_cycle  <= sr[7:0];
                  default: ;
               endcase
               if (ncs_fall) begin
                  state <= SHIFT;
                  cnt   <= '0;
                  sr    <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SPI_READBACK_EN
   logic       sclk_fall, rd;
   logic [6:0] rd_addr;
   logic [7:0] rd_data, tx;

   assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
   // Address is complete on the 8th sampled bit: seven bits in sr plus the incoming one.
   assign rd_addr   = {sr[5:0], copi_s};

   always_comb begin
      rd_data = 8'h00;
      case (rd_addr)
         7'h00:   rd_data = en_reg_out_7_0;
         7'h01:   rd_data = en_reg_out_15_8;
         7'h02:   rd_data = en_reg_pwm_7_0;
         7'h03:   rd_data = en_reg_pwm_15_8;
         7'h04:   rd_data = pwm_duty_cycle;
         default: rd_data = 8'h00;
      endcase
      if (rd_addr > MAX_ADDR) rd_data = 8'h00;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cipo <= 1'b0;
         tx   <= '0;
         rd   <= 1'b0;
      end else if (ncs_s) begin
         cipo <= 1'b0;
         tx   <= '0;
         rd   <= 1'b0;
      end else if (state == SHIFT && sclk_rise && cnt == 5'd7 && !sr[6]) begin
         tx <= rd_data;
         rd <= 1'b1;
      end else if (rd && sclk_fall && cnt >= 5'd8 && cnt <= 5'd15) begin
         cipo <= tx[7];
         tx   <= {tx[6:0], 1'b0};
      end
   end
`else
   assign cipo = 1'b0;
`endif

endmodule
